snake_game_ctrl: RTL

Parametrised game-flow controller for the snake game. It replaces the fixed tick timer and the single running flag with a four-state FSM (idle/run/pause/over), a variable-period step generator and score/level tracking. The tick period shortens as the level rises. It sits between key_control, which supplies start and pause, and snake_field, which reports collision and food_eaten and consumes step.

---
 rtl/snake_game_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the snake game: idle/run/pause/over FSM, level-dependent step
// generator and score/level tracking. Define SNAKE_HISCORE_EN to build the hi_score register.
module snake_game_ctrl #(
    parameter int BASE_TICK_CLK   = 12000000,
    parameter int MIN_TICK_CLK    = 3000000,
    parameter int TICK_DEC_CLK    = 1000000,
    parameter int FOODS_PER_LEVEL = 5,
    parameter int SCORE_W         = 10,
    parameter int LEVEL_W         = 4,
    parameter int CNT_W           = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               collision,
    input  logic               food_eaten,
    output logic               step,
    output logic [1:0]         state,
    output logic               running,
    output logic               game_over,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic [CNT_W-1:0]   period,
    output logic [SCORE_W-1:0] hi_score
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

    localparam int FCNT_W = $clog2(FOODS_PER_LEVEL + 1);
    localparam logic [CNT_W-1:0]  BASE      = CNT_W'(BASE_TICK_CLK);
    localparam logic [CNT_W-1:0]  MIN_P     = CNT_W'(MIN_TICK_CLK);
    localparam logic [CNT_W-1:0]  DEC_P     = CNT_W'(TICK_DEC_CLK);
    localparam logic [CNT_W:0]    DEC_FLOOR = (CNT_W+1)'(MIN_TICK_CLK + TICK_DEC_CLK);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FOODS_PER_LEVEL - 1);

    state_t            st;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  pend;
    logic [FCNT_W-1:0] fcnt;
    logic              restart;

    // A collision in RUN outranks a simultaneous start.
    assign restart   = start && !(st == RUN && collision);
    assign state     = st;
    assign running   = (st == RUN);
    assign game_over = (st == OVER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            step   <= 1'b0;
            cnt    <= '0;
            fcnt   <= '0;
            score  <= '0;
            level  <= '0;
            period <= BASE;
            pend   <= BASE;
        end else begin
            step <= 1'b0;
            if (restart) begin
                st     <= RUN;
                cnt    <= '0;
                fcnt   <= '0;
                score  <= '0;
                level  <= '0;
                period <= BASE;
                pend   <= BASE;
            end else begin
                case (st)
                    RUN: begin
                        if (collision) begin
                            st <= OVER;
                        end else begin
                            if (food_eaten) begin
                                if (score != '1) score <= score + 1'b1;
                                if (fcnt == FCNT_LAST) begin
                                    fcnt <= '0;
                                    if (level != '1) level <= level + 1'b1;
                                    // Compare first so the subtraction can never wrap below zero.
                                    if ({1'b0, pend} >= DEC_FLOOR) pend <= pend - DEC_P;
                                    else                           pend <= MIN_P;
                                end else begin
                                    fcnt <= fcnt + 1'b1;
                                end
                            end
                            if (pause) begin
                                st <= PAUSE;
                            end else if (cnt == period - 1'b1) begin
                                cnt    <= '0;
                                step   <= 1'b1;
                                period <= pend;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (pause) st <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SNAKE_HISCORE_EN
    logic [SCORE_W-1:0] hi_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= '0;
        end else if (st == RUN && collision && score > hi_r) begin
            hi_r <= score;
        end
    end

    assign hi_score = hi_r;
`else
    assign hi_score = '0;
`endif

endmodule
